// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - multi-cycle MUL/IMUL sequencer around a shared 8x8 multiplier
// Optional signed support is built when IMUL_EN is defined.
module mul_sequencer #(
  parameter int DONE_HOLD = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_mode,
  input  logic        signed_op,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        cf_of,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic [15:0] mul_p
);

  typedef enum logic [2:0] {IDLE, PP0, PP1, PP2, PP3, FIN} state_t;

  state_t      state;
  logic [15:0] a_reg, b_reg;
  logic        word_reg, neg_reg, sgn_reg;
  logic [31:0] acc;

  logic [15:0] a_mag, b_mag;
  logic        neg_in, sgn_in;
  logic [7:0]  a_lo_neg, b_lo_neg;

  // Operand magnitudes and product sign, captured at the accepting edge
  always_comb begin
    a_mag    = byte_mode ? {8'h00, op_a[7:0]} : op_a;
    b_mag    = byte_mode ? {8'h00, op_b[7:0]} : op_b;
    neg_in   = 1'b0;
    sgn_in   = 1'b0;
    a_lo_neg = -op_a[7:0];
    b_lo_neg = -op_b[7:0];
`ifdef IMUL_EN
    if (signed_op) begin
      sgn_in = 1'b1;
      if (byte_mode) begin
        neg_in = op_a[7] ^ op_b[7];
        if (op_a[7]) a_mag = {8'h00, a_lo_neg};
        if (op_b[7]) b_mag = {8'h00, b_lo_neg};
      end else begin
        neg_in = op_a[15] ^ op_b[15];
        if (op_a[15]) a_mag = -op_a;
        if (op_b[15]) b_mag = -op_b;
      end
    end
`endif
  end

`ifndef IMUL_EN
  logic unused_signed;
  assign unused_signed = signed_op ^ (^a_lo_neg) ^ (^b_lo_neg);
`endif

  logic [31:0] fin_res;
  logic [15:0] fin_lo;
  logic        fin_cf;

  always_comb begin
    fin_res = 32'h0;
    fin_lo  = 16'h0;
    fin_cf  = 1'b0;
    if (word_reg) begin
      fin_res = neg_reg ? -acc : acc;
      fin_cf  = sgn_reg ? (fin_res[31:16] != {16{fin_res[15]}})
                        : (fin_res[31:16] != 16'h0);
    end else begin
      fin_lo  = neg_reg ? -acc[15:0] : acc[15:0];
      fin_res = {16'h0, fin_lo};
      fin_cf  = sgn_reg ? (fin_lo[15:8] != {8{fin_lo[7]}})
                        : (fin_lo[15:8] != 8'h0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= 32'h0;
      cf_of    <= 1'b0;
      mul_a    <= 8'h0;
      mul_b    <= 8'h0;
      a_reg    <= 16'h0;
      b_reg    <= 16'h0;
      word_reg <= 1'b0;
      neg_reg  <= 1'b0;
      sgn_reg  <= 1'b0;
      acc      <= 32'h0;
    end else begin
      if (DONE_HOLD == 0) done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg    <= a_mag;
            b_reg    <= b_mag;
            word_reg <= ~byte_mode;
            neg_reg  <= neg_in;
            sgn_reg  <= sgn_in;
            acc      <= 32'h0;
            mul_a    <= a_mag[7:0];
            mul_b    <= b_mag[7:0];
            busy     <= 1'b1;
            done     <= 1'b0;
            state    <= PP0;
          end
        end
        PP0: begin
          acc <= acc + {16'h0, mul_p};
          if (word_reg) begin
            mul_a <= a_reg[7:0];
            mul_b <= b_reg[15:8];
            state <= PP1;
          end else begin
            mul_a <= 8'h0;
            mul_b <= 8'h0;
            state <= FIN;
          end
        end
        PP1: begin
          acc   <= acc + {8'h0, mul_p, 8'h0};
          mul_a <= a_reg[15:8];
          mul_b <= b_reg[7:0];
          state <= PP2;
        end
        PP2: begin
          acc   <= acc + {8'h0, mul_p, 8'h0};
          mul_a <= a_reg[15:8];
          mul_b <= b_reg[15:8];
          state <= PP3;
        end
        PP3: begin
          acc   <= acc + {mul_p, 16'h0};
          mul_a <= 8'h0;
          mul_b <= 8'h0;
          state <= FIN;
        end
        FIN: begin
          result <= fin_res;
          cf_of  <= fin_cf;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// tb/tb_mul_sequencer.sv - directed self-checking bench for mul_sequencer
// Expected values depend on whether IMUL_EN is defined.
module tb_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        byte_mode = 1'b0;
  logic        signed_op = 1'b0;
  logic [15:0] op_a = 16'h0;
  logic [15:0] op_b = 16'h0;

  logic        busy, done, cf_of;
  logic [31:0] result;
  logic [7:0]  mul_a, mul_b;
  logic [15:0] mul_p;

  logic        busy_h, done_h, cf_of_h;
  logic [31:0] result_h;
  logic [7:0]  mul_a_h, mul_b_h;
  logic [15:0] mul_p_h;

  assign mul_p   = mul_a * mul_b;
  assign mul_p_h = mul_a_h * mul_b_h;

  mul_sequencer #(.DONE_HOLD(0)) u_dut (
    .clk(clk), .rst(rst), .start(start), .byte_mode(byte_mode), .signed_op(signed_op),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result), .cf_of(cf_of),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p)
  );

  mul_sequencer #(.DONE_HOLD(1)) u_hold (
    .clk(clk), .rst(rst), .start(start), .byte_mode(byte_mode), .signed_op(signed_op),
    .op_a(op_a), .op_b(op_b), .busy(busy_h), .done(done_h), .result(result_h), .cf_of(cf_of_h),
    .mul_a(mul_a_h), .mul_b(mul_b_h), .mul_p(mul_p_h)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic run(input logic [15:0] a, input logic [15:0] b, input logic bm, input logic so,
                     input logic [31:0] er, input logic ecf, input logic [7:0] ema,
                     input logic [7:0] emb);
    int n;
    op_a = a; op_b = b; byte_mode = bm; signed_op = so; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op_a = 16'h5A5A; op_b = 16'hA5A5; byte_mode = ~bm; signed_op = ~so;
    check("busy_e0", busy, 1);
    check("done_e0", done, 0);
    check("done_hold_e0", done_h, 0);
    check("mul_a_pp0", mul_a, ema);
    check("mul_b_pp0", mul_b, emb);
    n = bm ? 2 : 5;
    for (int i = 1; i < n; i++) begin
      @(posedge clk); #1;
      check("busy_run", busy, 1);
    end
    check("mul_a_fin", mul_a, 0);
    check("mul_b_fin", mul_b, 0);
    @(posedge clk); #1;
    check("done", done, 1);
    check("busy_end", busy, 0);
    check("result", result, er);
    check("cf_of", cf_of, ecf);
    check("result_hold", result_h, er);
    check("done_hold", done_h, 1);
    check("mul_a_idle", mul_a, 0);
    @(posedge clk); #1;
    check("done_pulse", done, 0);
    check("done_hold_stay", done_h, 1);
    check("result_keep", result, er);
  endtask

  initial begin
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_cf", cf_of, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run(16'h1234, 16'h5678, 1'b0, 1'b0, 32'h06260060, 1'b1, 8'h34, 8'h78);
    run(16'h000F, 16'h0011, 1'b1, 1'b0, 32'h000000FF, 1'b0, 8'h0F, 8'h11);
    run(16'hAB0F, 16'hCD11, 1'b1, 1'b0, 32'h000000FF, 1'b0, 8'h0F, 8'h11);

    // start held high through the whole operation, operands change mid-flight
    op_a = 16'hFFFF; op_b = 16'hFFFF; byte_mode = 1'b0; signed_op = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    op_a = 16'h0002;
    repeat (4) begin
      @(posedge clk); #1;
      check("busy_held", busy, 1);
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("held_done", done, 1);
    check("held_result", result, 32'hFFFE0001);
    check("held_cf", cf_of, 1);
    @(posedge clk); #1;
    check("held_idle_busy", busy, 0);
    check("held_result_keep", result, 32'hFFFE0001);

    // asynchronous reset in PP2
    op_a = 16'h1234; op_b = 16'h5678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pp2_mul_a", mul_a, 8'h12);
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_result", result, 0);
    check("arst_cf", cf_of, 0);
    check("arst_mul_a", mul_a, 0);
    check("arst_mul_b", mul_b, 0);
    check("arst_done_hold", done_h, 0);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    run(16'h0003, 16'h0004, 1'b0, 1'b0, 32'h0000000C, 1'b0, 8'h03, 8'h04);

`ifdef IMUL_EN
    run(16'hFFFE, 16'h0003, 1'b0, 1'b1, 32'hFFFFFFFA, 1'b0, 8'h02, 8'h03);
    run(16'h0080, 16'h0002, 1'b1, 1'b1, 32'h0000FF00, 1'b1, 8'h80, 8'h02);
    run(16'h8000, 16'h0001, 1'b0, 1'b1, 32'hFFFF8000, 1'b0, 8'h00, 8'h01);
`else
    run(16'hFFFE, 16'h0003, 1'b0, 1'b1, 32'h0002FFFA, 1'b1, 8'hFE, 8'h03);
    run(16'h0080, 16'h0002, 1'b1, 1'b1, 32'h00000100, 1'b1, 8'h80, 8'h02);
    run(16'h8000, 16'h0001, 1'b0, 1'b1, 32'h00008000, 1'b0, 8'h00, 8'h01);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("done_hold_idle", done_h, 1);
    check("done_pulse_idle", done, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule
